// File: rtl/vx_rsp_tag_sched_pkg.sv
// vx_rsp_sched_pkg: shared types and helpers for the core-response batch scheduler.
//   sched_state_e : scheduler states (IDLE, LOCK)
//   age_width()   : width of the per-bank skip counters for a given MAX_AGE
//   tag_id_match(): compares only the low id_bits of two tags (tags up to 32 bits)
package vx_rsp_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_state_e;

  localparam int TAG_CMP_W = 32;

  function automatic int age_width(input int max_age);
    return $clog2(max_age + 1);
  endfunction

  // Callers zero-extend their tags to TAG_CMP_W bits before comparing.
  function automatic logic tag_id_match(input logic [TAG_CMP_W-1:0] tag_a,
                                        input logic [TAG_CMP_W-1:0] tag_b,
                                        input int                   id_bits);
    logic [TAG_CMP_W-1:0] mask_v;
    mask_v = (id_bits >= TAG_CMP_W) ? {TAG_CMP_W{1'b1}}
                                    : ((32'd1 << id_bits) - 32'd1);
    return ((tag_a ^ tag_b) & mask_v) == {TAG_CMP_W{1'b0}};
  endfunction

endpackage

// File: rtl/vx_rsp_tag_sched_age_rr_picker.sv
// vx_age_rr_picker: combinational leader picker.
//   valid      : per-bank request/response present
//   ages       : per-bank skip counters, AGE_W bits each, bank 0 in the low bits
//   rr_ptr     : round-robin start position
//   leader_idx : chosen bank (lowest aged bank, else first valid at/after rr_ptr)
//   found      : at least one bank is valid
module vx_age_rr_picker #(
  parameter int NUM_BANKS = 4,
  parameter int MAX_AGE   = 15,
  parameter int AGE_W     = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_BANKS-1:0]       valid,
  input  logic [NUM_BANKS*AGE_W-1:0] ages,
  input  logic [IDX_W-1:0]           rr_ptr,
  output logic [IDX_W-1:0]           leader_idx,
  output logic                       found
);

  logic             aged_found_s;
  logic [IDX_W-1:0] aged_idx_s;
  logic [IDX_W-1:0] rr_idx_s;

  // Aged scan runs from the top index down so the lowest aged bank is written last.
  always_comb begin
    aged_found_s = 1'b0;
    aged_idx_s   = {IDX_W{1'b0}};
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (valid[i] && (ages[i*AGE_W +: AGE_W] >= AGE_W'(MAX_AGE))) begin
        aged_found_s = 1'b1;
        aged_idx_s   = IDX_W'(i);
      end else begin
        aged_found_s = aged_found_s;
        aged_idx_s   = aged_idx_s;
      end
    end
  end

  // Round-robin scan: offsets descend so the nearest valid slot after rr_ptr wins.
  always_comb begin
    int sum_v;
    int slot_v;
    sum_v    = 0;
    slot_v   = 0;
    rr_idx_s = {IDX_W{1'b0}};
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      sum_v  = int'(rr_ptr) + k;
      slot_v = (sum_v >= NUM_BANKS) ? (sum_v - NUM_BANKS) : sum_v;
      if (valid[slot_v[IDX_W-1:0]]) begin
        rr_idx_s = slot_v[IDX_W-1:0];
      end else begin
        rr_idx_s = rr_idx_s;
      end
    end
  end

  assign found      = |valid;
  assign leader_idx = aged_found_s ? aged_idx_s : rr_idx_s;

endmodule

// File: rtl/vx_rsp_tag_sched_chk.sv
// vx_rsp_tag_sched_chk: protocol checker for the scheduler.
//   lock       : scheduler is holding a batch
//   lead_valid : bank_valid of the latched leader bank
module vx_rsp_tag_sched_chk (
  input logic clk,
  input logic reset_n,
  input logic lock,
  input logic lead_valid
);

  // A bank may not withdraw its response while it leads a locked batch.
  a_lead_stable: assert property (@(posedge clk) disable iff (!reset_n) lock |-> lead_valid);

endmodule

// File: rtl/vx_rsp_tag_sched.sv
// vx_rsp_tag_sched: groups bank responses sharing the leader's tag ID into one batch
// and holds it until the core response bus accepts it.
//   bank_valid/bank_tag/bank_ready : per-bank response handshake (bank i in slice i)
//   out_valid/out_tag/out_bmask    : batch presented downstream, out_ready accepts it
//   perf_batches / perf_stalls     : accepted batches / cycles stalled by out_ready
module vx_rsp_tag_sched
  import vx_rsp_sched_pkg::*;
#(
  parameter int NUM_BANKS        = 4,
  parameter int CORE_TAG_WIDTH   = 8,
  parameter int CORE_TAG_ID_BITS = 2,
  parameter int MAX_AGE          = 15
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_BANKS-1:0]                bank_valid,
  input  logic [NUM_BANKS*CORE_TAG_WIDTH-1:0] bank_tag,
  output logic [NUM_BANKS-1:0]                bank_ready,
  output logic                                out_valid,
  output logic [CORE_TAG_WIDTH-1:0]           out_tag,
  output logic [NUM_BANKS-1:0]                out_bmask,
  input  logic                                out_ready,
  output logic [31:0]                         perf_batches,
  output logic [31:0]                         perf_stalls
);

  localparam int AGE_W = age_width(MAX_AGE);
  localparam int IDX_W = $clog2(NUM_BANKS);

  sched_state_e               state_r;
  logic [IDX_W-1:0]           lead_idx_r;
  logic [CORE_TAG_WIDTH-1:0]  lead_tag_r;
  logic [IDX_W-1:0]           rr_ptr_r;
  logic [NUM_BANKS*AGE_W-1:0] age_r;
  logic [31:0]                perf_batches_r;
  logic [31:0]                perf_stalls_r;

  logic                       lock_s;
  logic [NUM_BANKS-1:0]       bmask_s;
  logic [IDX_W-1:0]           pick_idx_s;
  logic                       pick_found_s;
  logic [CORE_TAG_WIDTH-1:0]  pick_tag_s;

  assign lock_s = (state_r == LOCK);

  vx_age_rr_picker #(
    .NUM_BANKS (NUM_BANKS),
    .MAX_AGE   (MAX_AGE),
    .AGE_W     (AGE_W),
    .IDX_W     (IDX_W)
  ) u_picker (
    .valid      (bank_valid),
    .ages       (age_r),
    .rr_ptr     (rr_ptr_r),
    .leader_idx (pick_idx_s),
    .found      (pick_found_s)
  );

  // Tag of the bank the picker selected, latched as lead_tag on entry to LOCK.
  always_comb begin
    pick_tag_s = {CORE_TAG_WIDTH{1'b0}};
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        pick_tag_s = bank_tag[i*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
      end else begin
        pick_tag_s = pick_tag_s;
      end
    end
  end

  // Batch membership is live: a matching bank arriving mid-LOCK joins the batch.
  always_comb begin
    bmask_s = {NUM_BANKS{1'b0}};
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (lock_s && bank_valid[i] &&
          tag_id_match(TAG_CMP_W'(bank_tag[i*CORE_TAG_WIDTH +: CORE_TAG_WIDTH]),
                       TAG_CMP_W'(lead_tag_r), CORE_TAG_ID_BITS)) begin
        bmask_s[i] = 1'b1;
      end else begin
        bmask_s[i] = 1'b0;
      end
    end
  end

  // Scheduler FSM with leader latch, rr pointer, bank ages and perf counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      lead_idx_r     <= {IDX_W{1'b0}};
      lead_tag_r     <= {CORE_TAG_WIDTH{1'b0}};
      rr_ptr_r       <= {IDX_W{1'b0}};
      age_r          <= {(NUM_BANKS*AGE_W){1'b0}};
      perf_batches_r <= 32'd0;
      perf_stalls_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r    <= LOCK;
            lead_idx_r <= pick_idx_s;
            lead_tag_r <= pick_tag_s;
          end
        end
        LOCK: begin
          if (out_ready) begin
            state_r        <= IDLE;
            rr_ptr_r       <= (lead_idx_r == IDX_W'(NUM_BANKS - 1)) ? {IDX_W{1'b0}}
                                                                    : lead_idx_r + IDX_W'(1);
            perf_batches_r <= perf_batches_r + 32'd1;
            // Served or empty banks restart; skipped banks age, saturating.
            for (int i = 0; i < NUM_BANKS; i++) begin
              if (bmask_s[i] || !bank_valid[i]) begin
                age_r[i*AGE_W +: AGE_W] <= {AGE_W{1'b0}};
              end else if (age_r[i*AGE_W +: AGE_W] < AGE_W'(MAX_AGE)) begin
                age_r[i*AGE_W +: AGE_W] <= age_r[i*AGE_W +: AGE_W] + AGE_W'(1);
              end else begin
                age_r[i*AGE_W +: AGE_W] <= age_r[i*AGE_W +: AGE_W];
              end
            end
          end else begin
            perf_stalls_r <= perf_stalls_r + 32'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign out_valid    = lock_s;
  assign out_tag      = lead_tag_r;
  assign out_bmask    = bmask_s;
  assign bank_ready   = bmask_s & {NUM_BANKS{out_ready}};
  assign perf_batches = perf_batches_r;
  assign perf_stalls  = perf_stalls_r;

  vx_rsp_tag_sched_chk u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .lock       (lock_s),
    .lead_valid (bank_valid[lead_idx_r])
  );

endmodule

// File: tb/tb_vx_rsp_tag_sched.sv
// Directed bench for vx_rsp_tag_sched (MAX_AGE=2). Stimulus pushes the hand-computed
// batch {tag, bmask} into a queue; a monitor pops and compares on every handshake.
module tb_vx_rsp_tag_sched;

  logic        clk;
  logic        reset_n;
  logic [3:0]  bank_valid;
  logic [31:0] bank_tag;
  logic [3:0]  bank_ready;
  logic        out_valid;
  logic [7:0]  out_tag;
  logic [3:0]  out_bmask;
  logic        out_ready;
  logic [31:0] perf_batches;
  logic [31:0] perf_stalls;

  typedef struct packed {
    logic [7:0] tag;
    logic [3:0] bmask;
  } exp_t;

  exp_t       exp_q[$];
  int         checks;
  int         failures;
  logic [3:0] rdy_seen;
  logic [3:0] refill_mask;

  vx_rsp_tag_sched #(
    .NUM_BANKS        (4),
    .CORE_TAG_WIDTH   (8),
    .CORE_TAG_ID_BITS (2),
    .MAX_AGE          (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bank_valid   (bank_valid),
    .bank_tag     (bank_tag),
    .bank_ready   (bank_ready),
    .out_valid    (out_valid),
    .out_tag      (out_tag),
    .out_bmask    (out_bmask),
    .out_ready    (out_ready),
    .perf_batches (perf_batches),
    .perf_stalls  (perf_stalls)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] tag, input logic [3:0] bmask);
    exp_t e;
    e.tag   = tag;
    e.bmask = bmask;
    exp_q.push_back(e);
  endtask

  task automatic set_tag(input int b, input logic [7:0] t);
    bank_tag[b*8 +: 8] = t;
  endtask

  // One clock: consumed banks drop valid unless marked for immediate refill.
  task automatic cyc();
    @(posedge clk);
    #1;
    bank_valid = (bank_valid & ~rdy_seen) | (rdy_seen & refill_mask);
  endtask

  task automatic drain(input int left, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > left && n < budget) begin
      cyc();
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'(left));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    rdy_seen = 4'd0;
    forever begin
      @(negedge clk);
      rdy_seen = bank_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got tag 0x%0h bmask 0x%0h required no batch", out_tag, out_bmask);
        end else begin
          e = exp_q.pop_front();
          check("sb_tag", 32'(out_tag), 32'(e.tag));
          check("sb_bmask", 32'(out_bmask), 32'(e.bmask));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    bank_valid  = 4'd0;
    bank_tag    = 32'd0;
    out_ready   = 1'b0;
    refill_mask = 4'd0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bmask", 32'(out_bmask), 32'd0);
    check("rst_bank_ready", 32'(bank_ready), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_perf_batches", perf_batches, 32'd0);
    check("rst_perf_stalls", perf_stalls, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // T1: single bank, one-cycle latency
    out_ready = 1'b1;
    set_tag(2, 8'h15);
    bank_valid = 4'b0100;
    push(8'h15, 4'b0100);
    @(negedge clk);
    check("t1_idle_no_valid", 32'(out_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_bank_ready", 32'(bank_ready), 32'h4);
    cyc();
    check("t1_perf_batches", perf_batches, 32'd1);
    @(negedge clk);
    check("t1_ready_one_cycle", 32'(bank_ready), 32'd0);
    check("t1_back_idle", 32'(out_valid), 32'd0);

    // T2: tag-ID grouping, rr_ptr = 0
    do_reset();
    set_tag(0, 8'h41);
    set_tag(1, 8'h82);
    set_tag(3, 8'h05);
    bank_valid = 4'b1011;
    push(8'h41, 4'b1001);
    push(8'h82, 4'b0010);
    drain(0, 20);
    check("t2_perf_batches", perf_batches, 32'd2);

    // T3: stall with a late joiner (rr_ptr = 2 -> bank 2 leads)
    out_ready = 1'b0;
    set_tag(0, 8'h11);
    set_tag(2, 8'h26);
    bank_valid = 4'b0101;
    push(8'h26, 4'b0110);
    push(8'h11, 4'b0001);
    cyc();
    @(negedge clk);
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_out_tag", 32'(out_tag), 32'h26);
    check("t3_bmask_initial", 32'(out_bmask), 32'h4);
    check("t3_no_ready", 32'(bank_ready), 32'd0);
    cyc();
    cyc();
    set_tag(1, 8'h5A);
    bank_valid[1] = 1'b1;
    @(negedge clk);
    check("t3_bmask_joined", 32'(out_bmask), 32'h6);
    check("t3_no_ready_joined", 32'(bank_ready), 32'd0);
    cyc();
    cyc();
    check("t3_stalls_4", perf_stalls, 32'd4);
    @(negedge clk);
    check("t3_tag_held", 32'(out_tag), 32'h26);
    cyc();
    check("t3_stalls_5", perf_stalls, 32'd5);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ready", 32'(bank_ready), 32'h6);
    drain(0, 20);
    check("t3_stalls_final", perf_stalls, 32'd5);
    check("t3_perf_batches", perf_batches, 32'd4);

    // T4: aging override with MAX_AGE=2
    do_reset();
    set_tag(0, 8'h10);
    set_tag(1, 8'h24);
    set_tag(2, 8'h38);
    set_tag(3, 8'h33);
    bank_valid  = 4'b1111;
    refill_mask = 4'b0111;
    push(8'h10, 4'b0111);
    push(8'h24, 4'b0111);
    push(8'h33, 4'b1000);
    push(8'h10, 4'b0111);
    drain(1, 30);
    refill_mask = 4'b0000;
    drain(0, 20);
    check("t4_perf_batches", perf_batches, 32'd4);

    // T5: distinct IDs, leaders 0,1,2,3 then rr_ptr wraps to 0
    do_reset();
    set_tag(0, 8'h40);
    set_tag(1, 8'h51);
    set_tag(2, 8'h62);
    set_tag(3, 8'h73);
    bank_valid = 4'b1111;
    push(8'h40, 4'b0001);
    push(8'h51, 4'b0010);
    push(8'h62, 4'b0100);
    push(8'h73, 4'b1000);
    drain(0, 30);
    bank_valid = 4'b1001;
    push(8'h40, 4'b0001);
    push(8'h73, 4'b1000);
    drain(0, 20);

    // T7: reset mid-batch, then the still-valid bank is served
    out_ready = 1'b0;
    set_tag(1, 8'h9D);
    bank_valid = 4'b0010;
    cyc();
    @(negedge clk);
    check("t7_locked", 32'(out_valid), 32'd1);
    cyc();
    check("t7_stall_pre", perf_stalls, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t7_rst_out_valid", 32'(out_valid), 32'd0);
    check("t7_rst_bank_ready", 32'(bank_ready), 32'd0);
    check("t7_rst_bmask", 32'(out_bmask), 32'd0);
    check("t7_rst_tag", 32'(out_tag), 32'd0);
    check("t7_rst_batches", perf_batches, 32'd0);
    check("t7_rst_stalls", perf_stalls, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    push(8'h9D, 4'b0010);
    @(negedge clk);
    check("t7_idle_after_release", 32'(out_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("t7_relock", 32'(out_valid), 32'd1);
    check("t7_ready", 32'(bank_ready), 32'h2);
    cyc();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
